// File: rtl/scene_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : scene_sequencer                                               |
// | Purpose  : Top-level scene FSM START -> MENU -> PLAY(level n) -> WIN/LOSE |
// |            -> MENU, with NUM_LEVELS grid-placed menu buttons, a result   |
// |            screen click hold-off, a registered one-shot game_init and a  |
// |            frame-driven twinkle counter.                                 |
// | Ports    : clk, rst (async, active-high), frame_tick, mouse_x/y,         |
// |            mouse_l, game_win, game_lose, pause_req (inputs);             |
// |            scene[2:0], level[LW-1:0], game_init, in_play, hover_start,   |
// |            hover_level[NUM_LEVELS-1:0], twinkle (outputs).               |
// | Options  : `define PAUSE_SCENE_EN enables the PAUSED scene (code 5).     |
// |            Without it pause_req is ignored and scene 5 is unreachable.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module scene_sequencer #(
  parameter int NUM_LEVELS  = 3,
  parameter int BTN_X0      = 160,
  parameter int BTN_X1      = 480,
  parameter int BTN_Y0      = 80,
  parameter int BTN_H       = 60,
  parameter int BTN_PITCH   = 120,
  parameter int START_X0    = 200,
  parameter int START_X1    = 440,
  parameter int START_Y0    = 270,
  parameter int START_Y1    = 330,
  parameter int RESULT_HOLD = 60,
  parameter int TWINKLE_DIV = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame_tick,
  input  logic [9:0]                          mouse_x,
  input  logic [9:0]                          mouse_y,
  input  logic                                mouse_l,
  input  logic                                game_win,
  input  logic                                game_lose,
  input  logic                                pause_req,
  output logic [2:0]                          scene,
  output logic [$clog2(NUM_LEVELS+1)-1:0]     level,
  output logic                                game_init,
  output logic                                in_play,
  output logic                                hover_start,
  output logic [NUM_LEVELS-1:0]               hover_level,
  output logic                                twinkle
);

  localparam int LW = $clog2(NUM_LEVELS + 1);
  localparam int PW = (TWINKLE_DIV > 1) ? $clog2(TWINKLE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TWINKLE_DIV - 1);
  localparam logic [7:0]    HOLD_LOAD  = 8'(RESULT_HOLD);
  localparam logic [31:0]   SX0 = START_X0;
  localparam logic [31:0]   SX1 = START_X1;
  localparam logic [31:0]   SY0 = START_Y0;
  localparam logic [31:0]   SY1 = START_Y1;
  localparam logic [31:0]   BX0 = BTN_X0;
  localparam logic [31:0]   BX1 = BTN_X1;

  typedef enum logic [2:0] {
    SC_START  = 3'd0,
    SC_MENU   = 3'd1,
    SC_PLAY   = 3'd2,
    SC_WIN    = 3'd3,
    SC_LOSE   = 3'd4,
    SC_PAUSED = 3'd5
  } scene_e;

  scene_e          scene_q, scene_d;
  logic [LW-1:0]   level_q, level_d;
  logic            game_init_q, game_init_d;
  logic [7:0]      hold_q, hold_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      twk_q, twk_d;

  // Coordinates are compared at full integer width so that button edges
  // placed beyond the 10-bit cursor range simply never match.
  logic [31:0]           x_w, y_w;
  logic                  in_start_w;
  logic [NUM_LEVELS-1:0] in_btn_w;
  logic                  sel_hit_w;
  logic [LW-1:0]         sel_lvl_w;

  assign x_w = {22'd0, mouse_x};
  assign y_w = {22'd0, mouse_y};

  assign in_start_w = (x_w >= SX0) && (x_w < SX1) && (y_w >= SY0) && (y_w < SY1);

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_btn
    localparam logic [31:0] Y_TOP = 32'(BTN_Y0 + i * BTN_PITCH);
    localparam logic [31:0] Y_BOT = 32'(BTN_Y0 + i * BTN_PITCH + BTN_H);
    assign in_btn_w[i] = (x_w >= BX0) && (x_w < BX1) && (y_w >= Y_TOP) && (y_w < Y_BOT);
  end

  // Overlapping buttons: scan from the top index down so the lowest index
  // hit is the one left in sel_lvl_w.
  always_comb begin
    sel_hit_w = 1'b0;
    sel_lvl_w = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (in_btn_w[i]) begin
        sel_hit_w = 1'b1;
        sel_lvl_w = LW'(i + 1);
      end
    end
  end

  // Scene / level / hold-off next-state logic.
  always_comb begin
    scene_d     = scene_q;
    level_d     = level_q;
    game_init_d = 1'b0;
    hold_d      = hold_q;
    case (scene_q)
      SC_START: begin
        if (mouse_l && in_start_w) begin
          scene_d = SC_MENU;
          level_d = '0;
        end
      end
      SC_MENU: begin
        if (mouse_l && sel_hit_w) begin
          scene_d     = SC_PLAY;
          level_d     = sel_lvl_w;
          game_init_d = 1'b1;
        end
      end
      SC_PLAY: begin
        if (game_win) begin
          scene_d = SC_WIN;
          hold_d  = HOLD_LOAD;
        end else if (game_lose) begin
          scene_d = SC_LOSE;
          hold_d  = HOLD_LOAD;
        end
`ifdef PAUSE_SCENE_EN
        else if (pause_req) begin
          scene_d = SC_PAUSED;
        end
`endif
      end
      SC_WIN, SC_LOSE: begin
        // The click test uses the hold value from before this cycle's
        // decrement, so a click coinciding with the final tick is ignored.
        if (mouse_l && (hold_q == 8'd0)) begin
          scene_d = SC_MENU;
          level_d = '0;
        end else if (frame_tick && (hold_q != 8'd0)) begin
          hold_d = hold_q - 8'd1;
        end
      end
`ifdef PAUSE_SCENE_EN
      SC_PAUSED: begin
        if (pause_req) begin
          scene_d = SC_PLAY;
        end
      end
`endif
      default: begin
        scene_d = SC_START;
        level_d = '0;
      end
    endcase
  end

`ifndef PAUSE_SCENE_EN
  logic unused_pause;
  assign unused_pause = pause_req;
`endif

  // Twinkle prescaler and 3-bit counter; frozen while paused.
  always_comb begin
    presc_d = presc_q;
    twk_d   = twk_q;
    if (frame_tick && (scene_q != SC_PAUSED)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        twk_d   = twk_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene_q     <= SC_START;
      level_q     <= '0;
      game_init_q <= 1'b0;
      hold_q      <= 8'd0;
      presc_q     <= '0;
      twk_q       <= 3'd0;
    end else begin
      scene_q     <= scene_d;
      level_q     <= level_d;
      game_init_q <= game_init_d;
      hold_q      <= hold_d;
      presc_q     <= presc_d;
      twk_q       <= twk_d;
    end
  end

  assign scene       = scene_q;
  assign level       = level_q;
  assign game_init   = game_init_q;
  assign in_play     = (scene_q == SC_PLAY);
  assign hover_start = (scene_q == SC_START) && in_start_w;
  assign hover_level = (scene_q == SC_MENU) ? in_btn_w : '0;
  assign twinkle     = twk_q[2];

endmodule
`default_nettype wire

// File: tb/tb_scene_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_scene_sequencer                                            |
// | Purpose  : Self-checking bench for scene_sequencer (default parameters). |
// |            Honours `define PAUSE_SCENE_EN when the design is built so.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_scene_sequencer;

  localparam int NL   = 3;
  localparam int HOLD = 60;
  localparam int DIV  = 6;
`ifdef PAUSE_SCENE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, mouse_l, game_win, game_lose, pause_req;
  logic [9:0] mouse_x, mouse_y;
  logic [2:0] scene;
  logic [1:0] level;
  logic       game_init, in_play, hover_start, twinkle;
  logic [NL-1:0] hover_level;

  always #20 clk = ~clk;

  scene_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_l(mouse_l),
    .game_win(game_win), .game_lose(game_lose), .pause_req(pause_req),
    .scene(scene), .level(level), .game_init(game_init), .in_play(in_play),
    .hover_start(hover_start), .hover_level(hover_level), .twinkle(twinkle)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: scene code, level, init pulse, hold counter and the
  // total number of frame ticks seen while not paused.
  int m_scene, m_level, m_hold, m_ticks;
  int m_init;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_btn(input int i, input int x, input int y);
    int top = 80 + i * 120;
    return (x >= 160) && (x < 480) && (y >= top) && (y < top + 60);
  endfunction

  function automatic bit m_in_start(input int x, input int y);
    return (x >= 200) && (x < 440) && (y >= 270) && (y < 330);
  endfunction

  function automatic int m_mask(input int x, input int y);
    int m = 0;
    for (int i = 0; i < NL; i++) if (m_in_btn(i, x, y)) m += (1 << i);
    return m;
  endfunction

  function automatic int m_first(input int x, input int y);
    for (int i = 0; i < NL; i++) if (m_in_btn(i, x, y)) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_scene = 0; m_level = 0; m_hold = 0; m_ticks = 0; m_init = 0;
  endtask

  task automatic m_step(input bit ft, input int x, input int y, input bit l,
                        input bit w, input bit lo, input bit p);
    int ns = m_scene, nl = m_level, nh = m_hold, ni = 0;
    int sel = m_first(x, y);
    case (m_scene)
      0: if (l && m_in_start(x, y)) ns = 1;
      1: if (l && sel >= 0) begin ns = 2; nl = sel + 1; ni = 1; end
      2: begin
        if (w) begin ns = 3; nh = HOLD; end
        else if (lo) begin ns = 4; nh = HOLD; end
        else if (PAUSE_EN && p) ns = 5;
      end
      3, 4: begin
        if (l && m_hold == 0) begin ns = 1; nl = 0; end
        else if (ft && m_hold > 0) nh = m_hold - 1;
      end
      5: if (p) ns = 2;
      default: begin ns = 0; nl = 0; end
    endcase
    if (ft && m_scene != 5) m_ticks++;
    m_scene = ns; m_level = nl; m_hold = nh; m_init = ni;
  endtask

  function automatic int m_twinkle();
    return (((m_ticks / DIV) % 8) >= 4) ? 1 : 0;
  endfunction

  task automatic chk_regs();
    chk("scene", scene, m_scene);
    chk("level", level, m_level);
    chk("game_init", game_init, m_init);
    chk("in_play", in_play, (m_scene == 2) ? 1 : 0);
    chk("twinkle", twinkle, m_twinkle());
  endtask

  // One clock: drive at the falling edge, check hover combinationally, then
  // check registered outputs just after the rising edge.
  task automatic cyc(input bit ft, input int x, input int y, input bit l,
                     input bit w, input bit lo, input bit p);
    @(negedge clk);
    frame_tick = ft; mouse_x = 10'(x); mouse_y = 10'(y); mouse_l = l;
    game_win = w; game_lose = lo; pause_req = p;
    #1;
    chk("hover_start", hover_start, (m_scene == 0 && m_in_start(x, y)) ? 1 : 0);
    chk("hover_level", hover_level, (m_scene == 1) ? m_mask(x, y) : 0);
    @(posedge clk);
    m_step(ft, x, y, l, w, lo, p);
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 0; mouse_l = 0; game_win = 0; game_lose = 0; pause_req = 0;
    mouse_x = 0; mouse_y = 0;
    m_reset();
    #1;
    chk_regs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit ft; int x; int y; bit l; bit w; bit lo; bit p;
    int e_scene; int e_level; int e_init;
  } vec_t;

  vec_t tbl[8];

  typedef struct { int x; int y; int mask; } hov_t;
  hov_t htbl[8];

  initial begin
    // ft, x, y, l, win, lose, pause, scene, level, init
    tbl[0] = '{0, 100, 300, 1, 0, 0, 0, 0, 0, 0};  // miss on start screen
    tbl[1] = '{0, 300, 300, 1, 0, 0, 0, 1, 0, 0};  // start button
    tbl[2] = '{0, 200, 150, 1, 0, 0, 0, 1, 0, 0};  // gap between buttons
    tbl[3] = '{0, 300, 100, 0, 1, 1, 0, 1, 0, 0};  // win/lose ignored in MENU
    tbl[4] = '{0, 200, 210, 1, 0, 0, 0, 2, 2, 1};  // button 1 -> level 2
    tbl[5] = '{0,   0,   0, 0, 0, 0, 0, 2, 2, 0};  // init pulse gone
    tbl[6] = '{0,   0,   0, 0, 1, 1, 0, 3, 2, 0};  // win beats lose
    tbl[7] = '{0, 300, 300, 1, 0, 0, 0, 3, 2, 0};  // click during hold-off

    htbl[0] = '{160,  80, 1};
    htbl[1] = '{479, 139, 1};
    htbl[2] = '{159, 100, 0};
    htbl[3] = '{480, 100, 0};
    htbl[4] = '{300, 140, 0};
    htbl[5] = '{300, 200, 2};
    htbl[6] = '{300, 379, 4};
    htbl[7] = '{300, 380, 0};

    rst = 1'b1;
    do_reset();

    // Table-driven scene walk.
    foreach (tbl[i]) begin
      cyc(tbl[i].ft, tbl[i].x, tbl[i].y, tbl[i].l, tbl[i].w, tbl[i].lo, tbl[i].p);
      chk($sformatf("tbl%0d_scene", i), scene, tbl[i].e_scene);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].e_level);
      chk($sformatf("tbl%0d_init", i), game_init, tbl[i].e_init);
    end

    // Result hold-off: 59 ticks, click ignored; 60th tick with click ignored;
    // then a click returns to MENU.
    for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 300, 300, 1, 0, 0, 0);
    chk("hold59_scene", scene, 3);
    cyc(1, 300, 300, 1, 0, 0, 0);
    chk("hold60_same_cycle_scene", scene, 3);
    cyc(0, 300, 300, 1, 0, 0, 0);
    chk("hold_done_scene", scene, 1);
    chk("hold_done_level", level, 0);

    // Hover boundaries in MENU.
    foreach (htbl[i]) begin
      cyc(0, htbl[i].x, htbl[i].y, 0, 0, 0, 0);
      chk($sformatf("hov%0d", i), hover_level, htbl[i].mask);
    end

    // Lose path and async reset in the middle of PLAY at level 2.
    cyc(0, 200, 210, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lose_scene", scene, 4);
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 200, 210, 1, 0, 0, 0);
    chk("replay_level", level, 2);
    chk("replay_init", game_init, 1);
    #5;
    rst = 1'b1;
    #1;
    chk("async_rst_scene", scene, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_init", game_init, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Twinkle from reset: 24 ticks -> counter 4; 60 ticks -> counter 2.
    do_reset();
    for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("twinkle_24", twinkle, 1);
    for (int i = 0; i < 36; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("twinkle_60", twinkle, 0);

    // Pause handling.
    do_reset();
    cyc(0, 300, 300, 1, 0, 0, 0);
    cyc(0, 200, 100, 1, 0, 0, 0);
    chk("pause_setup_level", level, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
`ifdef PAUSE_SCENE_EN
    chk("paused_scene", scene, 5);
    chk("paused_in_play", in_play, 0);
    for (int i = 0; i < 30; i++) cyc(1, 200, 100, 1, 1, 1, 0);
    chk("paused_hold_scene", scene, 5);
    chk("paused_twinkle", twinkle, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("resume_scene", scene, 2);
    chk("resume_level", level, 1);
    chk("resume_init", game_init, 0);
`else
    chk("pause_ignored_scene", scene, 2);
    chk("pause_ignored_in_play", in_play, 1);
`endif

    // Randomised run against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int x, y;
      x = ($urandom_range(0, 1) == 0) ? $urandom_range(140, 500) : $urandom_range(0, 1023);
      y = $urandom_range(0, 479);
      cyc($urandom_range(0, 1) == 1, x, y, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
